// File: rtl/output_selecter_top.sv
// Return-path/result stage of the 4x4 2D FFT: transposes the row-pass result back
// to the input selector, then captures, re-transposes and scales the column-pass result.
module output_selecter_top #(
  parameter int DW      = 16,
  parameter int SCALE   = 0,
  parameter int TIMEOUT = 64
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           in_valid,
  input  logic [16*DW-1:0] fft_r,
  input  logic [16*DW-1:0] fft_i,
  output logic           sel,
  output logic [16*DW-1:0] rt_r,
  output logic [16*DW-1:0] rt_i,
  output logic           rt_valid,
  output logic [16*DW-1:0] out_r,
  output logic [16*DW-1:0] out_i,
  output logic           out_valid,
  output logic           busy,
  output logic           err
);

  // A zero-width counter is illegal, so TIMEOUT=0 still keeps one (unused) bit.
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] LIMIT = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

  typedef enum logic [1:0] {IDLE, ROW, COL} state_t;

  state_t          state, state_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic            load_rt, load_out, err_n, timed_out;
  logic [16*DW-1:0] tr_r, tr_i, sc_r, sc_i;

  always_comb begin
    tr_r = '0;
    tr_i = '0;
    sc_r = '0;
    sc_i = '0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        tr_r[(4*r+c)*DW +: DW] = fft_r[(4*c+r)*DW +: DW];
        tr_i[(4*r+c)*DW +: DW] = fft_i[(4*c+r)*DW +: DW];
        sc_r[(4*r+c)*DW +: DW] = DW'($signed(fft_r[(4*c+r)*DW +: DW]) >>> SCALE);
        sc_i[(4*r+c)*DW +: DW] = DW'($signed(fft_i[(4*c+r)*DW +: DW]) >>> SCALE);
      end
    end
  end

  // A result arriving on the limit cycle wins over the timeout.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    load_rt   = 1'b0;
    load_out  = 1'b0;
    err_n     = 1'b0;
    timed_out = (TIMEOUT != 0) && (cnt == LIMIT);
    case (state)
      IDLE: begin
        if (start) begin
          state_n = ROW;
          cnt_n   = '0;
        end
      end
      ROW: begin
        if (in_valid) begin
          load_rt = 1'b1;
          state_n = COL;
          cnt_n   = '0;
        end else if (timed_out) begin
          err_n   = 1'b1;
          state_n = IDLE;
          cnt_n   = '0;
        end else if (TIMEOUT != 0) begin
          cnt_n = cnt + 1'b1;
        end
      end
      COL: begin
        if (in_valid) begin
          load_out = 1'b1;
          state_n  = IDLE;
          cnt_n    = '0;
        end else if (timed_out) begin
          err_n   = 1'b1;
          state_n = IDLE;
          cnt_n   = '0;
        end else if (TIMEOUT != 0) begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // Control outputs follow the next state so they are valid the cycle it is entered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel       <= 1'b0;
      rt_valid  <= 1'b0;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      err       <= 1'b0;
      rt_r      <= '0;
      rt_i      <= '0;
      out_r     <= '0;
      out_i     <= '0;
    end else begin
      sel       <= (state_n == COL);
      rt_valid  <= (state_n == COL);
      busy      <= (state_n != IDLE);
      out_valid <= load_out;
      err       <= err_n;
      if (load_rt) begin
        rt_r <= tr_r;
        rt_i <= tr_i;
      end
      if (load_out) begin
        out_r <= sc_r;
        out_i <= sc_i;
      end
    end
  end

endmodule

// File: tb/tb_output_selecter_top.sv
// Self-checking bench for output_selecter_top: vector table of pass latencies plus
// hand-written reset, transpose, back-to-back, stray-valid and timeout sequences.
module tb_output_selecter_top;

  localparam int DW      = 16;
  localparam int SCALE   = 2;
  localparam int TIMEOUT = 8;
  localparam int VW      = 16 * DW;

  logic          clk = 1'b0;
  logic          rst, start, in_valid;
  logic [VW-1:0] fft_r, fft_i;
  logic          sel, rt_valid, out_valid, busy, err;
  logic [VW-1:0] rt_r, rt_i, out_r, out_i;

  output_selecter_top #(.DW(DW), .SCALE(SCALE), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
    .fft_r(fft_r), .fft_i(fft_i), .sel(sel), .rt_r(rt_r), .rt_i(rt_i),
    .rt_valid(rt_valid), .out_r(out_r), .out_i(out_i), .out_valid(out_valid),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [VW-1:0] r;
    logic [VW-1:0] i;
  } res_t;

  // row_lat/col_lat: idle cycles in that pass before in_valid; -1 means never (timeout)
  typedef struct {
    string name;
    int    row_lat;
    int    col_lat;
  } vec_t;

  int            checks = 0;
  int            fails  = 0;
  res_t          sbq[$];
  res_t          mon_exp;
  logic [VW-1:0] exp_rt_r, exp_rt_i, exp_out_r, exp_out_i;
  vec_t          vecs[6];

  task automatic checkOutput(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic checkOutputBit(input string name, input logic act, input logic exp);
    checkOutput(name, VW'(act), VW'(exp));
  endtask

  task automatic checkOutputEl(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checkOutput(name, VW'(act), VW'(exp));
  endtask

  function automatic logic [DW-1:0] el(input logic [VW-1:0] v, input int r, input int c);
    return v[(4*r+c)*DW +: DW];
  endfunction

  function automatic logic [VW-1:0] transposeM(input logic [VW-1:0] v);
    logic [VW-1:0] t;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        t[(4*r+c)*DW +: DW] = v[(4*c+r)*DW +: DW];
    return t;
  endfunction

  // floor division by 2**SCALE
  function automatic logic [VW-1:0] scaleM(input logic [VW-1:0] v);
    logic [VW-1:0] s;
    int e, d, q;
    d = 1 << SCALE;
    for (int k = 0; k < 16; k++) begin
      e = int'($signed(v[k*DW +: DW]));
      q = (e >= 0) ? e / d : -((-e + d - 1) / d);
      s[k*DW +: DW] = DW'(q);
    end
    return s;
  endfunction

  function automatic logic [VW-1:0] randVec();
    logic [VW-1:0] v;
    for (int k = 0; k < 16; k++) v[k*DW +: DW] = DW'($urandom);
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic s, input logic v, input logic [VW-1:0] dr, input logic [VW-1:0] di);
    start    = s;
    in_valid = v;
    fft_r    = dr;
    fft_i    = di;
    tick();
    start    = 1'b0;
    in_valid = 1'b0;
  endtask

  task automatic rowCapture(input logic [VW-1:0] dr, input logic [VW-1:0] di);
    exp_rt_r = transposeM(dr);
    exp_rt_i = transposeM(di);
    applyStimulus(1'b0, 1'b1, dr, di);
  endtask

  task automatic colCapture(input logic [VW-1:0] dr, input logic [VW-1:0] di);
    exp_out_r = scaleM(transposeM(dr));
    exp_out_i = scaleM(transposeM(di));
    sbq.push_back('{exp_out_r, exp_out_i});
    applyStimulus(1'b0, 1'b1, dr, di);
  endtask

  task automatic checkTimeout(input string name);
    repeat (7) tick();
    checkOutputBit({name, "_err_early"}, err, 1'b0);
    tick();
    checkOutputBit({name, "_err"}, err, 1'b1);
    checkOutputBit({name, "_busy"}, busy, 1'b0);
    checkOutputBit({name, "_sel"}, sel, 1'b0);
    checkOutputBit({name, "_rt_valid"}, rt_valid, 1'b0);
    checkOutput({name, "_rt_kept"}, rt_r, exp_rt_r);
    checkOutput({name, "_out_kept"}, out_r, exp_out_r);
    tick();
    checkOutputBit({name, "_err_pulse"}, err, 1'b0);
  endtask

  task automatic runVector(input vec_t v);
    applyStimulus(1'b1, 1'b0, fft_r, fft_i);
    checkOutputBit({v.name, "_busy"}, busy, 1'b1);
    if (v.row_lat < 0) begin
      checkTimeout({v.name, "_row"});
      return;
    end
    repeat (v.row_lat) tick();
    rowCapture(randVec(), randVec());
    checkOutput({v.name, "_rt_r"}, rt_r, exp_rt_r);
    checkOutput({v.name, "_rt_i"}, rt_i, exp_rt_i);
    checkOutputBit({v.name, "_rt_valid"}, rt_valid, 1'b1);
    checkOutputBit({v.name, "_sel1"}, sel, 1'b1);
    checkOutputBit({v.name, "_err_row"}, err, 1'b0);
    if (v.col_lat < 0) begin
      checkTimeout({v.name, "_col"});
      return;
    end
    repeat (v.col_lat) tick();
    colCapture(randVec(), randVec());
    checkOutputBit({v.name, "_out_valid"}, out_valid, 1'b1);
    checkOutputBit({v.name, "_sel0"}, sel, 1'b0);
    checkOutputBit({v.name, "_rt_valid0"}, rt_valid, 1'b0);
    checkOutputBit({v.name, "_busy0"}, busy, 1'b0);
    checkOutputBit({v.name, "_err_col"}, err, 1'b0);
    tick();
    checkOutputBit({v.name, "_out_valid_pulse"}, out_valid, 1'b0);
  endtask

  // Scoreboard: every out_valid must match the oldest expected result.
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (sbq.size() == 0) begin
        checks++;
        fails++;
        $display("[TB] FAIL unexpected_out_valid: got 1 expected 0");
      end else begin
        mon_exp = sbq.pop_front();
        checkOutput("sb_out_r", out_r, mon_exp.r);
        checkOutput("sb_out_i", out_i, mon_exp.i);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected end of test");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [VW-1:0] pat_r, pat_i, col_r;

    vecs[0] = '{"fast",      0,  0};
    vecs[1] = '{"mid",       2,  5};
    vecs[2] = '{"limit",     7,  7};
    vecs[3] = '{"col_tmo",   3, -1};
    vecs[4] = '{"row_tmo",  -1,  0};
    vecs[5] = '{"mixed",     1,  3};

    rst = 1'b1; start = 1'b0; in_valid = 1'b0; fft_r = '0; fft_i = '0;
    exp_rt_r = '0; exp_rt_i = '0; exp_out_r = '0; exp_out_i = '0;
    repeat (2) tick();
    checkOutputBit("rst_sel", sel, 1'b0);
    checkOutputBit("rst_busy", busy, 1'b0);
    checkOutputBit("rst_rt_valid", rt_valid, 1'b0);
    checkOutputBit("rst_out_valid", out_valid, 1'b0);
    checkOutputBit("rst_err", err, 1'b0);
    checkOutput("rst_rt_r", rt_r, '0);
    checkOutput("rst_out_r", out_r, '0);
    rst = 1'b0;
    tick();
    checkOutputBit("post_rst_busy", busy, 1'b0);

    // Transpose, ignored starts, scaled full pass and back-to-back start
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        pat_r[(4*r+c)*DW +: DW] = DW'(16*r + c);
        pat_i[(4*r+c)*DW +: DW] = DW'(-(16*r + c));
      end
    applyStimulus(1'b1, 1'b0, '0, '0);
    checkOutputBit("start_busy", busy, 1'b1);
    applyStimulus(1'b1, 1'b0, '0, '0);
    checkOutputBit("row_start_ign_sel", sel, 1'b0);
    checkOutputBit("row_start_ign_busy", busy, 1'b1);
    rowCapture(pat_r, pat_i);
    checkOutputEl("tr_rt_r12", el(rt_r, 1, 2), 16'h0021);
    checkOutputEl("tr_rt_i12", el(rt_i, 1, 2), 16'hFFDF);
    checkOutputEl("tr_rt_r30", el(rt_r, 3, 0), 16'h0003);
    checkOutputBit("tr_sel", sel, 1'b1);
    checkOutputBit("tr_rt_valid", rt_valid, 1'b1);
    applyStimulus(1'b1, 1'b0, pat_r, pat_i);
    checkOutputBit("col_start_ign_sel", sel, 1'b1);
    checkOutputBit("col_start_ign_busy", busy, 1'b1);
    repeat (3) tick();
    col_r = randVec();
    col_r[(4*0+1)*DW +: DW] = DW'(-7);
    col_r[(4*2+3)*DW +: DW] = DW'(100);
    colCapture(col_r, randVec());
    checkOutputEl("full_out_r10", el(out_r, 1, 0), 16'hFFFE);
    checkOutputEl("full_out_r32", el(out_r, 3, 2), 16'd25);
    checkOutputBit("full_out_valid", out_valid, 1'b1);
    checkOutputBit("full_sel", sel, 1'b0);
    checkOutputBit("full_busy", busy, 1'b0);
    applyStimulus(1'b1, 1'b0, '0, '0);
    checkOutputBit("b2b_out_valid", out_valid, 1'b0);
    checkOutputBit("b2b_busy", busy, 1'b1);
    rowCapture(randVec(), randVec());
    checkOutput("b2b_rt_r", rt_r, exp_rt_r);
    colCapture(randVec(), randVec());
    checkOutputBit("b2b_col_next_cycle", out_valid, 1'b1);
    tick();

    // Stray in_valid in IDLE
    repeat (3) applyStimulus(1'b0, 1'b1, randVec(), randVec());
    checkOutputBit("stray_busy", busy, 1'b0);
    checkOutputBit("stray_sel", sel, 1'b0);
    checkOutputBit("stray_rt_valid", rt_valid, 1'b0);
    checkOutput("stray_rt_r", rt_r, exp_rt_r);
    checkOutput("stray_rt_i", rt_i, exp_rt_i);
    checkOutput("stray_out_r", out_r, exp_out_r);
    checkOutput("stray_out_i", out_i, exp_out_i);

    foreach (vecs[n]) runVector(vecs[n]);

    // Asynchronous reset in the middle of the column pass
    applyStimulus(1'b1, 1'b0, '0, '0);
    rowCapture(randVec(), randVec());
    tick();
    #2 rst = 1'b1;
    #1;
    checkOutputBit("arst_sel", sel, 1'b0);
    checkOutputBit("arst_busy", busy, 1'b0);
    checkOutputBit("arst_rt_valid", rt_valid, 1'b0);
    checkOutput("arst_rt_r", rt_r, '0);
    checkOutput("arst_out_r", out_r, '0);
    #2 rst = 1'b0;
    exp_rt_r = '0; exp_rt_i = '0; exp_out_r = '0; exp_out_i = '0;
    for (int k = 0; k < 10; k++) begin
      tick();
      checkOutputBit("arst_no_err", err, 1'b0);
    end
    applyStimulus(1'b0, 1'b1, randVec(), randVec());
    tick();
    checkOutputBit("arst_idle_busy", busy, 1'b0);
    checkOutput("arst_idle_rt_r", rt_r, '0);
    checkOutput("arst_idle_out_r", out_r, '0);

    tick();
    checkOutput("scoreboard_empty", VW'(sbq.size()), '0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/output_selecter_top.md
# output_selecter_top

Return-path and result stage of the 4x4 2D FFT. Captures each 16-point complex FFT result, transposes it, and presents it on the `rt_in_*` return path while driving `sel` so the input selector feeds the column pass. After the column pass it captures, re-transposes, optionally scales and publishes the final 4x4 spectrum with a one-cycle valid pulse. It owns pass sequencing, replacing the free-running selector control.

## Interface
- `DW`, 16: width of each real/imag element (matches `InBus`/`OutBus`).
- `SCALE`, 0: arithmetic right shift applied to final outputs, 0..DW-1.
- `TIMEOUT`, 64: max cycles waiting for `in_valid` per pass; 0 disables timeout.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: pulse; original 4x4 input is stable on the selector's `in_*` ports.
- `in_valid` in 1: FFT core result valid, one-cycle pulse.
- `fft_r`, `fft_i` in 16*DW: FFT result. Element (r,c), r,c in 0..3, is `[(4*r+c)*DW +: DW]`, signed.
- `sel` out 1: to input selector; 0 = original input, 1 = return path.
- `rt_r`, `rt_i` out 16*DW: return data to selector `rt_in_*`, same packing.
- `rt_valid` out 1: return data held valid.
- `out_r`, `out_i` out 16*DW: final 2D FFT result, same packing.
- `out_valid` out 1: one-cycle pulse, final result updated.
- `busy` out 1: transform in progress.
- `err` out 1: one-cycle pulse on timeout.

## Operation
- States: IDLE, ROW, COL.
- IDLE: `sel`=0, `busy`=0. `start`=1 goes to ROW and clears the wait counter. `in_valid` in IDLE is ignored.
- ROW: `sel`=0, `busy`=1.
  - On `in_valid`: `rt(r,c)` <= `fft(c,r)` for both r and i, `rt_valid`<=1, `sel`<=1, go to COL, clear counter.
- COL: `sel`=1, `rt_*` frozen.
  - On `in_valid`: `out(r,c)` <= `fft(c,r) >>> SCALE` (arithmetic shift, truncate toward -inf, DW bits), `out_valid` pulse, `rt_valid`<=0, `sel`<=0, go to IDLE.
- `start` in ROW or COL is ignored and not queued.
- Timeout applies in ROW and COL when `TIMEOUT`!=0.
  - Counter increments each cycle without `in_valid`.
  - When it reaches `TIMEOUT`-1: `err` pulse next cycle, go to IDLE, `sel`<=0, `rt_valid`<=0. `rt_*` and `out_*` data are kept.
  - `in_valid` in the same cycle the counter hits its limit takes priority; no `err`.
  - Counter width is `$clog2(TIMEOUT+1)`.
- `out_*` hold their value until the next completed transform. `rt_*` hold until the next ROW capture.

## Timing
- All outputs are registered.
- Reset: state IDLE, counter 0, `sel`=0, `rt_valid`=0, `out_valid`=0, `busy`=0, `err`=0, `rt_*`=0, `out_*`=0.
- `start` at cycle t: `busy`=1 from t+1.
- ROW `in_valid` at cycle k: `rt_*`, `rt_valid`=1 and `sel`=1 visible at k+1.
- COL `in_valid` at cycle m:
  - `out_*` and `out_valid`=1 at m+1 only.
  - `sel`=0, `rt_valid`=0, `busy`=0 at m+1.
  - `start` at m+1 is accepted.
- Minimum transform: start→ROW 1 cycle, plus FFT latency, plus 1 capture, plus FFT latency, plus 1.
- `in_valid` at cycle k+1 counts as the COL result. The FFT core must not re-present the row result.
- `rst` mid-transform aborts immediately. No `out_valid` or `err` is generated.

## Test plan
- **Reset:** assert `rst` asynchronously mid-COL → all outputs 0 in the same cycle, and the state stays IDLE after release.
- **Transpose:**
  - Stimulus: `start`; ROW `in_valid` with `fft_r`(r,c)=16*r+c and `fft_i`=−(16*r+c).
  - Required: next cycle `rt_r`(1,2)=0x21, `rt_i`(1,2)=−0x21, `rt_r`(3,0)=0x03, `sel`=1, `rt_valid`=1.
- **Full pass:**
  - Stimulus: `SCALE`=2; COL `in_valid` 5 cycles after the ROW `in_valid`, with `fft_r`(0,1)=−7 and `fft_r`(2,3)=100.
  - Required: `out_r`(1,0)=−2, `out_r`(3,2)=25, `out_valid` high for exactly 1 cycle, `sel`=0, `busy`=0.
- **Busy / back-to-back:**
  - Stimulus: `start` pulses during ROW and COL; `start` again on the `out_valid` cycle.
  - Required: the pulses during ROW/COL are ignored; the `out_valid`-cycle `start` gives `busy`=1 the next cycle.
- **Timeout:**
  - With `TIMEOUT`=8 and no `in_valid` after `start`: `err` pulses exactly 1 cycle, 9 cycles after `start`, and the state returns to IDLE.
  - With `in_valid` on the limit cycle: no `err`, and the block advances to COL.
- **Stray `in_valid`:** `in_valid` pulses in IDLE → no state change; `rt_*` and `out_*` unchanged.
